// File: rtl/rnbip_pkg.sv
// Shared RNBIP encodings: program-counter operations, jump conditions and the
// default address width.
package rnbip_pkg;

  localparam int RNBIP_ADDR_W = 8;

  typedef enum logic [2:0] {
    PC_HOLD  = 3'd0,
    PC_INC   = 3'd1,
    PC_JMP   = 3'd2,
    PC_JCOND = 3'd3,
    PC_CALL  = 3'd4,
    PC_RET   = 3'd5
  } pc_op_e;

  typedef enum logic [1:0] {
    CND_Z  = 2'd0,
    CND_NZ = 2'd1,
    CND_C  = 2'd2,
    CND_NC = 2'd3
  } cond_sel_e;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack for the program counter: storage, level counter,
// full/empty detection and a sticky overflow/underflow error.
module pc_return_stack
  import rnbip_pkg::*;
#(
  parameter int ADDR_W      = RNBIP_ADDR_W,
  parameter int STACK_DEPTH = 4,
  parameter int LVL_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic [LVL_W-1:0]  lvl,
  output logic              err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [LVL_W-1:0]  lvl_q;
  logic              err_q;
  logic              full;
  logic              do_push;
  logic              do_pop;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign full    = (lvl_q == LVL_W'(STACK_DEPTH));
  assign empty   = (lvl_q == '0);
  assign do_push = push_req && !full;
  assign do_pop  = pop_req && !empty;
  // Level never exceeds STACK_DEPTH-1 when a push is accepted, so the low
  // bits address the next free slot directly.
  assign wr_idx  = lvl_q[IDX_W-1:0];
  assign rd_idx  = lvl_q[IDX_W-1:0] - IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (do_push) begin
        lvl_q <= lvl_q + LVL_W'(1);
      end else if (do_pop) begin
        lvl_q <= lvl_q - LVL_W'(1);
      end
      if ((push_req && full) || (pop_req && empty)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

  assign top_data = mem[rd_idx];
  assign lvl      = lvl_q;
  assign err      = err_q;

endmodule

// File: rtl/program_counter.sv
// RNBIP program counter: INC/JMP/JCOND/CALL/RET sequencing onto the address bus.
// Build with PC_CALL_STACK_EN to get the hardware return stack; without it CALL acts as JMP and RET as HOLD.
module program_counter
  import rnbip_pkg::*;
#(
  parameter int                ADDR_W       = RNBIP_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                STACK_DEPTH  = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [2:0]                   PC_OP,
  input  logic [1:0]                   COND_SEL,
  input  logic                         FLAG_Z,
  input  logic                         FLAG_C,
  input  logic [ADDR_W-1:0]            OR_PC,
  input  logic                         E_PC,
  output logic [ADDR_W-1:0]            PC_addr,
  output logic [ADDR_W-1:0]            databusOut,
  output logic                         JUMP_TAKEN,
  output logic [$clog2(STACK_DEPTH):0] STK_LVL,
  output logic                         STK_ERR
);

  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic              jt_q, jt_nxt;
  logic              cond_ok;

`ifdef PC_CALL_STACK_EN
  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_empty;

  pc_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .LVL_W       (LVL_W)
  ) u_stack (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push_req  (stk_push),
    .pop_req   (stk_pop),
    .push_data (pc_q),
    .top_data  (stk_top),
    .empty     (stk_empty),
    .lvl       (STK_LVL),
    .err       (STK_ERR)
  );
`else
  assign STK_LVL = '0;
  assign STK_ERR = 1'b0;
`endif

  always_comb begin
    cond_ok = 1'b0;
    case (COND_SEL)
      CND_Z:   cond_ok = FLAG_Z;
      CND_NZ:  cond_ok = !FLAG_Z;
      CND_C:   cond_ok = FLAG_C;
      CND_NC:  cond_ok = !FLAG_C;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    pc_nxt = pc_q;
    jt_nxt = 1'b0;
`ifdef PC_CALL_STACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    case (PC_OP)
      PC_INC: pc_nxt = pc_q + ADDR_W'(1);
      PC_JMP: begin
        pc_nxt = OR_PC;
        jt_nxt = 1'b1;
      end
      PC_JCOND: begin
        if (cond_ok) begin
          pc_nxt = OR_PC;
          jt_nxt = 1'b1;
        end
      end
      // A full stack still jumps; the stack flags the lost return address.
      PC_CALL: begin
`ifdef PC_CALL_STACK_EN
        stk_push = 1'b1;
`endif
        pc_nxt = OR_PC;
        jt_nxt = 1'b1;
      end
      PC_RET: begin
`ifdef PC_CALL_STACK_EN
        stk_pop = 1'b1;
        if (!stk_empty) begin
          pc_nxt = stk_top;
          jt_nxt = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q <= RESET_VECTOR;
      jt_q <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      jt_q <= jt_nxt;
    end
  end

  assign PC_addr    = pc_q;
  assign JUMP_TAKEN = jt_q;
  assign databusOut = E_PC ? pc_q : '0;

endmodule
